// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and SPI mode constants for the byte master
// Contents: spi_state_t (IDLE/SHIFT/DONE), SPI_CPOL/SPI_CPHA, default half-period length.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

    localparam int SPI_CPOL = 0;
    localparam int SPI_CPHA = 0;

    localparam int DEFAULT_CLKS_PER_HALF_BIT = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period timer, SCLK toggle and edge counter
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   en            run the timer; when low all counters sit at zero and SCLK idles
//   sclk          generated serial clock
//   rise_pulse    one-cycle strobe coinciding with the clock edge that raises sclk
//   fall_pulse    one-cycle strobe coinciding with the clock edge that lowers sclk
//   last_edge     fall_pulse of the final (2*DATA_W-th) SCLK edge
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = DEFAULT_CLKS_PER_HALF_BIT,
    parameter int DATA_W            = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic last_edge
);

    localparam int HC_W = $clog2(CLKS_PER_HALF_BIT);
    localparam int EC_W = $clog2(2 * DATA_W) + 1;

    localparam logic [HC_W-1:0] HC_MAX    = HC_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EC_W-1:0] EC_LAST   = EC_W'(2 * DATA_W - 1);
    localparam logic            SCLK_IDLE = 1'(SPI_CPOL);

    logic [HC_W-1:0] half_cnt;
    logic [EC_W-1:0] edge_cnt;
    logic            wrap;

    // The pulses are combinational so the byte master acts on the very edge
    // that moves SCLK, keeping MOSI/MISO aligned with the pin.
    assign wrap       = en && (half_cnt == HC_MAX);
    assign rise_pulse = wrap && (sclk == SCLK_IDLE);
    assign fall_pulse = wrap && (sclk != SCLK_IDLE);
    assign last_edge  = fall_pulse && (edge_cnt == EC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            edge_cnt <= '0;
            sclk     <= SCLK_IDLE;
        end else if (!en) begin
            half_cnt <= '0;
            edge_cnt <= '0;
            sclk     <= SCLK_IDLE;
        end else if (wrap) begin
            half_cnt <= '0;
            edge_cnt <= edge_cnt + EC_W'(1);
            sclk     <= ~sclk;
        end else begin
            half_cnt <= half_cnt + HC_W'(1);
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - SPI mode-0 single-byte master (MSB first, full duplex)
// Ports:
//   i_Clk, i_Rst     system clock, asynchronous active-high reset
//   i_TX_Byte        byte to send, sampled only at accept
//   i_TX_DV          request; accepted on an edge where o_TX_Ready is high
//   o_TX_Ready       high in IDLE and DONE
//   o_RX_Byte        last byte captured from MISO, held until the next transfer ends
//   o_RX_DV          high for the single DONE cycle
//   o_SPI_Clk        SCLK, idles low
//   i_SPI_MISO       serial data in, sampled on SCLK rising edges
//   o_SPI_MOSI       serial data out, changed on SCLK falling edges
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = DEFAULT_CLKS_PER_HALF_BIT,
    parameter int DATA_W            = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] i_TX_Byte,
    input  logic              i_TX_DV,
    output logic              o_TX_Ready,
    output logic [DATA_W-1:0] o_RX_Byte,
    output logic              o_RX_DV,
    output logic              o_SPI_Clk,
    input  logic              i_SPI_MISO,
    output logic              o_SPI_MOSI
);

    spi_state_t        state;
    spi_state_t        next_state;
    logic              accept;
    logic              rise_pulse;
    logic              fall_pulse;
    logic              last_edge;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;

    spi_clk_gen #(
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
        .DATA_W            (DATA_W)
    ) u_clk_gen (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .en         (state == ST_SHIFT),
        .sclk       (o_SPI_Clk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .last_edge  (last_edge)
    );

    assign accept = i_TX_DV && o_TX_Ready;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE is also a ready state so a held request restarts on the very next
    // edge, giving back-to-back bytes with no idle cycle.
    always_comb begin
        next_state = state;
        o_TX_Ready = 1'b0;
        o_RX_DV    = 1'b0;
        case (state)
            ST_IDLE: begin
                o_TX_Ready = 1'b1;
                if (i_TX_DV) begin
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_edge) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                o_TX_Ready = 1'b1;
                o_RX_DV    = 1'b1;
                next_state = i_TX_DV ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // MOSI is driven from the accept edge, so the first bit has a full
    // half-period of setup before the first rising SCLK edge. The tx shifter
    // rotates so the bit after the current MSB is always at DATA_W-2.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            o_SPI_MOSI <= 1'b0;
            o_RX_Byte  <= '0;
        end else begin
            if (accept) begin
                tx_shift   <= i_TX_Byte;
                o_SPI_MOSI <= i_TX_Byte[DATA_W-1];
            end else if (fall_pulse && !last_edge) begin
                tx_shift   <= {tx_shift[DATA_W-2:0], tx_shift[DATA_W-1]};
                o_SPI_MOSI <= tx_shift[DATA_W-2];
            end
            if (rise_pulse) begin
                rx_shift <= {rx_shift[DATA_W-2:0], i_SPI_MISO};
            end
            // The final rising edge came a half-period earlier, so rx_shift is
            // complete here and the byte is valid throughout the DONE cycle.
            if (last_edge) begin
                o_RX_Byte <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - self-checking bench for spi_byte_master
module tb_spi_byte_master;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int H4 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_dv = 1'b0;
    logic       ready;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       sclk;
    logic       miso;
    logic       mosi;
    logic       loopback = 1'b1;
    logic       slave_bit = 1'b0;

    logic [7:0] tx_byte_b = 8'h00;
    logic       tx_dv_b = 1'b0;
    logic       ready_b;
    logic [7:0] rx_byte_b;
    logic       rx_dv_b;
    logic       sclk_b;
    logic       mosi_b;

    assign miso = loopback ? mosi : slave_bit;

    spi_byte_master #(.CLKS_PER_HALF_BIT(H), .DATA_W(W)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv),
        .o_TX_Ready(ready), .o_RX_Byte(rx_byte), .o_RX_DV(rx_dv),
        .o_SPI_Clk(sclk), .i_SPI_MISO(miso), .o_SPI_MOSI(mosi)
    );

    spi_byte_master #(.CLKS_PER_HALF_BIT(H4), .DATA_W(W)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte_b), .i_TX_DV(tx_dv_b),
        .o_TX_Ready(ready_b), .o_RX_Byte(rx_byte_b), .o_RX_DV(rx_dv_b),
        .o_SPI_Clk(sclk_b), .i_SPI_MISO(mosi_b), .o_SPI_MOSI(mosi_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation of dut_a: edges are numbered by cyc; a value seen at the
    // negedge after edge n is what edge n+1 samples.
    int         accept_edges[$];
    int         dv_edges[$];
    logic [7:0] rx_bytes[$];
    logic       mosi_bits[$];
    int         n_rise, width_err, per_err, stab_err, sclk_dv_err;
    int         last_rise = -1;
    logic       prev_sclk = 1'b0;
    logic       prev_mosi = 1'b0;
    logic [7:0] slave_byte = 8'h00;
    int         slave_idx = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (sclk && !prev_sclk) begin
                mosi_bits.push_back(mosi);
                if (mosi !== prev_mosi) stab_err++;
                if (last_rise >= 0 && (cyc - last_rise) != 2 * H) per_err++;
                last_rise = cyc;
                n_rise++;
            end
            if (!sclk && prev_sclk) begin
                if ((cyc - last_rise) != H) width_err++;
                slave_idx++;
                if (slave_idx < W) slave_bit = slave_byte[W-1-slave_idx];
            end
            if (rx_dv) begin
                dv_edges.push_back(cyc + 1);
                rx_bytes.push_back(rx_byte);
                if (sclk) sclk_dv_err++;
            end
            if (tx_dv && ready) begin
                accept_edges.push_back(cyc + 1);
                last_rise = -1;
                slave_idx = 0;
                slave_bit = slave_byte[W-1];
            end
        end
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        accept_edges = {};
        dv_edges     = {};
        rx_bytes     = {};
        mosi_bits    = {};
        n_rise = 0; width_err = 0; per_err = 0; stab_err = 0; sclk_dv_err = 0;
    endtask

    function automatic logic [7:0] bits_to_byte(input int start);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < W; i++) v = {v[6:0], mosi_bits[start + i]};
        return v;
    endfunction

    task automatic send(input logic [7:0] b);
        int guard = 0;
        @(posedge clk); #2;
        while (!ready && guard < 200) begin
            @(posedge clk); #2;
            guard++;
        end
        tx_byte = b;
        tx_dv   = 1'b1;
        @(posedge clk); #2;
        tx_dv   = 1'b0;
    endtask

    task automatic wait_dv(input int n);
        int guard = 0;
        while (dv_edges.size() < n && guard < 500) begin
            @(posedge clk); #2;
            guard++;
        end
        n_checks++;
        if (dv_edges.size() < n) begin
            n_fail++;
            $display("FAIL dv_timeout: got %0d strobes expected %0d", dv_edges.size(), n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #17;
        n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ready); end
        n_checks++; if (rx_dv !== 1'b0)  begin n_fail++; $display("FAIL rst_rx_dv: got %b expected 0", rx_dv); end
        n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_rx_byte: got %h expected 00", rx_byte); end
        n_checks++; if (sclk !== 1'b0)   begin n_fail++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
        n_checks++; if (mosi !== 1'b0)   begin n_fail++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
        @(posedge clk); #2;
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_loopback();
        clear_mon();
        loopback = 1'b1;
        send(8'hAC);
        wait_dv(1);
        idle(10);
        n_checks++; if (rx_bytes[0] !== 8'hAC) begin n_fail++; $display("FAIL lb_rx: got %h expected ac", rx_bytes[0]); end
        n_checks++; if (bits_to_byte(0) !== 8'hAC) begin n_fail++; $display("FAIL lb_mosi: got %h expected ac", bits_to_byte(0)); end
        n_checks++;
        if (dv_edges[0] - accept_edges[0] != 2 * W * H + 1) begin
            n_fail++; $display("FAIL lb_latency: got %0d expected %0d", dv_edges[0] - accept_edges[0], 2 * W * H + 1);
        end
        n_checks++; if (n_rise != W) begin n_fail++; $display("FAIL lb_rises: got %0d expected %0d", n_rise, W); end
        n_checks++;
        if (width_err != 0 || per_err != 0) begin
            n_fail++; $display("FAIL lb_sclk_shape: got %0d/%0d bad widths/periods expected 0/0", width_err, per_err);
        end
        n_checks++; if (dv_edges.size() != 1) begin n_fail++; $display("FAIL lb_dv_count: got %0d expected 1", dv_edges.size()); end
    endtask

    task automatic test_slave();
        clear_mon();
        loopback   = 1'b0;
        slave_byte = 8'h0E;
        send(8'hAA);
        wait_dv(1);
        idle(4);
        n_checks++; if (rx_bytes[0] !== 8'h0E) begin n_fail++; $display("FAIL slave_rx: got %h expected 0e", rx_bytes[0]); end
        n_checks++; if (bits_to_byte(0) !== 8'hAA) begin n_fail++; $display("FAIL slave_mosi: got %h expected aa", bits_to_byte(0)); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL slave_mosi_stable: got %0d changes expected 0", stab_err); end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        clear_mon();
        loopback = 1'b1;
        @(posedge clk); #2;
        tx_byte = 8'h12;
        tx_dv   = 1'b1;
        while (accept_edges.size() < 1 && guard < 100) begin @(posedge clk); #2; guard++; end
        tx_byte = 8'h34;
        while (accept_edges.size() < 2 && guard < 300) begin @(posedge clk); #2; guard++; end
        tx_dv = 1'b0;
        wait_dv(2);
        idle(4);
        n_checks++;
        if (accept_edges.size() != 2 || accept_edges[1] - accept_edges[0] != 2 * W * H + 1) begin
            n_fail++; $display("FAIL b2b_accept_gap: got %0d accepts expected second at +%0d", accept_edges.size(), 2 * W * H + 1);
        end
        n_checks++;
        if (dv_edges[1] - dv_edges[0] != 2 * W * H + 1) begin
            n_fail++; $display("FAIL b2b_dv_gap: got %0d expected %0d", dv_edges[1] - dv_edges[0], 2 * W * H + 1);
        end
        n_checks++;
        if ({bits_to_byte(0), bits_to_byte(8)} !== 16'h1234) begin
            n_fail++; $display("FAIL b2b_mosi: got %h expected 1234", {bits_to_byte(0), bits_to_byte(8)});
        end
        n_checks++;
        if (rx_bytes[0] !== 8'h12 || rx_bytes[1] !== 8'h34) begin
            n_fail++; $display("FAIL b2b_rx: got %h %h expected 12 34", rx_bytes[0], rx_bytes[1]);
        end
        n_checks++; if (sclk_dv_err != 0) begin n_fail++; $display("FAIL b2b_sclk_low: got %0d high expected 0", sclk_dv_err); end
    endtask

    task automatic test_ignore();
        int t0;
        clear_mon();
        loopback = 1'b1;
        send(8'hAC);
        t0 = accept_edges[0];
        while (cyc < t0 + 4) begin @(posedge clk); #2; end
        tx_byte = 8'hFF;
        tx_dv   = 1'b1;
        @(posedge clk); #2;
        tx_dv   = 1'b0;
        wait_dv(1);
        idle(12);
        n_checks++; if (accept_edges.size() != 1) begin n_fail++; $display("FAIL ign_accepts: got %0d expected 1", accept_edges.size()); end
        n_checks++; if (dv_edges.size() != 1) begin n_fail++; $display("FAIL ign_dv_count: got %0d expected 1", dv_edges.size()); end
        n_checks++; if (rx_bytes[0] !== 8'hAC) begin n_fail++; $display("FAIL ign_rx: got %h expected ac", rx_bytes[0]); end
        n_checks++; if (bits_to_byte(0) !== 8'hAC) begin n_fail++; $display("FAIL ign_mosi: got %h expected ac", bits_to_byte(0)); end
    endtask

    task automatic test_reset_mid();
        int t0;
        clear_mon();
        loopback = 1'b1;
        send(8'hFF);
        t0 = accept_edges[0];
        while (cyc < t0 + 9) begin @(posedge clk); #2; end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", ready); end
        n_checks++; if (mosi !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_mosi: got %b expected 0", mosi); end
        n_checks++; if (sclk !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_sclk: got %b expected 0", sclk); end
        n_checks++; if (rx_dv !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dv: got %b expected 0", rx_dv); end
        n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rx_byte: got %h expected 00", rx_byte); end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        idle(40);
        n_checks++; if (dv_edges.size() != 0) begin n_fail++; $display("FAIL mid_rst_no_strobe: got %0d expected 0", dv_edges.size()); end
        clear_mon();
        send(8'h5A);
        wait_dv(1);
        idle(4);
        n_checks++; if (rx_bytes[0] !== 8'h5A) begin n_fail++; $display("FAIL post_rst_rx: got %h expected 5a", rx_bytes[0]); end
        n_checks++; if (bits_to_byte(0) !== 8'h5A) begin n_fail++; $display("FAIL post_rst_mosi: got %h expected 5a", bits_to_byte(0)); end
        n_checks++;
        if (dv_edges[0] - accept_edges[0] != 2 * W * H + 1) begin
            n_fail++; $display("FAIL post_rst_latency: got %0d expected %0d", dv_edges[0] - accept_edges[0], 2 * W * H + 1);
        end
    endtask

    task automatic test_random();
        logic [7:0] t;
        logic [7:0] s;
        loopback = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            t = 8'($urandom);
            s = 8'($urandom);
            slave_byte = s;
            send(t);
            wait_dv(1);
            idle(2 + int'($urandom_range(0, 3)));
            n_checks++; if (rx_bytes[0] !== s) begin n_fail++; $display("FAIL rand_rx[%0d]: got %h expected %h", i, rx_bytes[0], s); end
            n_checks++; if (bits_to_byte(0) !== t) begin n_fail++; $display("FAIL rand_mosi[%0d]: got %h expected %h", i, bits_to_byte(0), t); end
        end
    endtask

    task automatic test_h4();
        int   t0;
        int   dv_edge = -1;
        int   last_r  = -1;
        int   rises   = 0;
        int   per_bad = 0;
        logic prev    = 1'b0;
        @(posedge clk); #2;
        tx_byte_b = 8'h81;
        tx_dv_b   = 1'b1;
        t0 = cyc + 1;
        @(posedge clk); #2;
        tx_dv_b = 1'b0;
        for (int i = 0; i < 200 && dv_edge < 0; i++) begin
            @(negedge clk);
            if (sclk_b && !prev) begin
                if (last_r >= 0 && (cyc - last_r) != 2 * H4) per_bad++;
                last_r = cyc;
                rises++;
            end
            prev = sclk_b;
            if (rx_dv_b) dv_edge = cyc + 1;
        end
        n_checks++;
        if (dv_edge - t0 != 2 * W * H4 + 1) begin
            n_fail++; $display("FAIL h4_latency: got %0d expected %0d", dv_edge - t0, 2 * W * H4 + 1);
        end
        n_checks++; if (rx_byte_b !== 8'h81) begin n_fail++; $display("FAIL h4_rx: got %h expected 81", rx_byte_b); end
        n_checks++; if (rises != W) begin n_fail++; $display("FAIL h4_rises: got %0d expected %0d", rises, W); end
        n_checks++; if (per_bad != 0) begin n_fail++; $display("FAIL h4_period: got %0d bad periods expected 0", per_bad); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_random();
        test_h4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
